// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 I/O bus master.
//   z80_phase_t     : bus phases, one per Z80 half-T-state plus IDLE
//   half_clocks()   : system clocks per Z80 half-T-state
//   strobe_phase()  : phases in which iorq_n and rd_n/wr_n are asserted
//   drive_phase()   : phases in which a write drives the data bus
package z80_bus_pkg;

  localparam int Z80_IO_TSTATES = 4;

  typedef enum logic [3:0] {
    IDLE,
    T1H,
    T1L,
    T2H,
    T2L,
    TWH,
    TWL,
    T3H,
    T3L
  } z80_phase_t;

  function automatic int half_clocks(input int clk_hz, input int z80_hz);
    return clk_hz / (2 * z80_hz);
  endfunction

  // Strobes fall at the start of T2 and rise at the start of T3L.
  function automatic logic strobe_phase(input z80_phase_t p);
    return (p == T2H) || (p == T2L) || (p == TWH) || (p == TWL) || (p == T3H);
  endfunction

  // Write data is on the bus from T1L until the end of T3L.
  function automatic logic drive_phase(input z80_phase_t p);
    return (p != IDLE) && (p != T1H);
  endfunction

endpackage

// File: rtl/z80_tstate_timer.sv
// Half-T-state prescaler.
//   clk, reset : system clock, synchronous active-high reset
//   restart    : start a fresh half-T-state on the next clock
//   phase_end  : high on the last clock of every half-T-state
// The counter reloads on every expiry, so consecutive half-T-states are
// exactly HALF clocks long with no accumulated drift.
module z80_tstate_timer #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic phase_end
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= CW'(HALF - 1);
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign phase_end = (cnt == '0);

endmodule

// File: rtl/z80_io_initiator.sv
// Z80-style I/O bus master. Converts a valid/ready request stream into
// Z80 IN/OUT bus cycles (T1, T2, mandatory TW, optional extra TWs, T3).
//   clk, reset              : system clock, synchronous active-high reset
//   req_valid/req_ready     : request handshake, ready only while idle
//   req_write/addr/wdata    : OUT (1) or IN (0), port number, write data
//   rsp_valid               : one-clock pulse at the start of T3L
//   rsp_rdata               : read data, held between responses
//   rsp_timeout             : qualifies rsp_valid, cycle aborted on WAIT
//   A, iorq_n, rd_n, wr_n   : Z80 address bus and strobes
//   cd_out, cd_oe, cd_in    : data bus drive value, enable, sampled value
//   wait_n                  : Z80 WAIT, already synchronised to clk
// All bus outputs are registered from the next phase, so the strobes are
// glitch-free and line up exactly with phase boundaries.
module z80_io_initiator
  import z80_bus_pkg::*;
#(
  parameter int CLK_FREQ     = 27_000_000,
  parameter int Z80_FREQ     = 3_375_000,
  parameter int WAIT_TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic [7:0] A,
  output logic       iorq_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] cd_out,
  output logic       cd_oe,
  input  logic [7:0] cd_in,
  input  logic       wait_n
);

  localparam int HALF = half_clocks(CLK_FREQ, Z80_FREQ);
  localparam int TW_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  z80_phase_t      state;
  z80_phase_t      next_state;
  logic            phase_end;
  logic            accept;
  logic            wr_sel;
  logic            more_wait;
  logic [TW_W-1:0] tw_cnt;
  logic            tw_inc;
  logic            tw_abort;

  assign accept = (state == IDLE) && req_ready && req_valid;

  z80_tstate_timer #(
    .HALF(HALF)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .restart  (accept),
    .phase_end(phase_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tw_inc     = 1'b0;
    tw_abort   = 1'b0;
    case (state)
      IDLE: if (accept) next_state = T1H;
      T1H:  if (phase_end) next_state = T1L;
      T1L:  if (phase_end) next_state = T2H;
      T2H:  if (phase_end) next_state = T2L;
      T2L:  if (phase_end) next_state = TWH;
      TWH: begin
        // wait_n is judged on the TW falling edge; once the number of extra
        // TW pairs already run reaches the limit, a still-low WAIT aborts.
        if (phase_end) begin
          if (!wait_n && (WAIT_TIMEOUT != 0) && (tw_cnt == TW_W'(WAIT_TIMEOUT))) begin
            next_state = T3L;
            tw_abort   = 1'b1;
          end else begin
            next_state = TWL;
          end
        end
      end
      TWL: begin
        if (phase_end) begin
          if (more_wait) begin
            next_state = TWH;
            tw_inc     = 1'b1;
          end else begin
            next_state = T3H;
          end
        end
      end
      T3H:     if (phase_end) next_state = T3L;
      T3L:     if (phase_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Wait bookkeeping: the mandatory TW is not counted, so the counter
  // advances only when another TWH is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      more_wait <= 1'b0;
      tw_cnt    <= '0;
    end else begin
      if (accept) begin
        tw_cnt <= '0;
      end else if (tw_inc && (tw_cnt != '1)) begin
        tw_cnt <= tw_cnt + TW_W'(1);
      end
      if ((state == TWH) && phase_end) begin
        more_wait <= ~wait_n;
      end
    end
  end

  // Bus and response registers, all driven from the phase being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready   <= 1'b0;
      A           <= '0;
      iorq_n      <= 1'b1;
      rd_n        <= 1'b1;
      wr_n        <= 1'b1;
      cd_out      <= '0;
      cd_oe       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
      wr_sel      <= 1'b0;
    end else begin
      req_ready <= (next_state == IDLE);
      if (accept) begin
        A      <= req_addr;
        wr_sel <= req_write;
        if (req_write) begin
          cd_out <= req_wdata;
        end
      end
      iorq_n      <= ~strobe_phase(next_state);
      rd_n        <= ~(strobe_phase(next_state) & ~wr_sel);
      wr_n        <= ~(strobe_phase(next_state) & wr_sel);
      cd_oe       <= wr_sel & drive_phase(next_state);
      rsp_valid   <= (next_state == T3L) && (state != T3L);
      rsp_timeout <= tw_abort;
      // Read data is taken on the last clock of T3H, just before the
      // strobes rise; an aborted cycle never passes through T3H.
      if ((state == T3H) && phase_end && !wr_sel) begin
        rsp_rdata <= cd_in;
      end
    end
  end

endmodule

// File: tb/tb_z80_io_initiator.sv
// Bench for z80_io_initiator: randomized Z80 I/O cycles checked against a
// timeline model (offsets from acceptance) plus a response scoreboard.
module tb_z80_io_initiator;

  localparam int WT  = 2;
  localparam int NTX = 36;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic [7:0] A;
  logic       iorq_n;
  logic       rd_n;
  logic       wr_n;
  logic [7:0] cd_out;
  logic       cd_oe;
  logic [7:0] cd_in;
  logic       wait_n;

  always #5 clk = ~clk;

  z80_io_initiator #(
    .CLK_FREQ    (27_000_000),
    .Z80_FREQ    (3_375_000),
    .WAIT_TIMEOUT(WT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .A          (A),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .cd_out     (cd_out),
    .cd_oe      (cd_oe),
    .cd_in      (cd_in),
    .wait_n     (wait_n)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       tmo;
    int         off;
    int         acc;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] model_rdata = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s t=%0t actual=0x%0h expected=0x%0h", name, $time, act, want);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest outstanding
  // expectation, including the clock offset from acceptance.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected t=%0t actual=rsp_valid expected=no response", $time);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", int'(rsp_rdata), int'(e.rdata));
        chk("rsp_timeout", int'(rsp_timeout), int'(e.tmo));
        chk("rsp_offset", cyc - e.acc, e.off);
      end
    end
  end

  // One bus cycle. The slave holds WAIT low for n Z80 clocks starting at
  // the mandatory TW; more than WT extra TWs ends in an abort. rst_at >= 0
  // asserts reset at that offset and checks the bus is released next clock.
  task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                         input int n, input logic [7:0] cap, input int rst_at);
    int   t3l;
    int   endo;
    int   w;
    logic tmo;
    logic strobe;
    exp_t e;
    if (n > WT) begin
      t3l = 20 + 8 * WT;
      tmo = 1'b1;
    end else begin
      t3l = 28 + 8 * n;
      tmo = 1'b0;
    end
    endo      = t3l + 4;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    chk("ready_at_present", int'(req_ready), 1);
    w = 0;
    while (req_ready !== 1'b1) begin
      if (w >= 100) begin
        checks++;
        failures++;
        $display("FAIL accept_wait t=%0t actual=req_ready low expected=high within 100 clocks", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    if (rst_at < 0) begin
      e.rdata = (wr || tmo) ? model_rdata : cap;
      e.tmo   = tmo;
      e.off   = t3l;
      e.acc   = cyc;
      exp_q.push_back(e);
      model_rdata = e.rdata;
    end
    for (int k = 0; k <= endo; k++) begin
      if (k > 0) @(negedge clk);
      if (rst_at >= 0 && k == rst_at + 1) begin
        chk("rst_iorq_n", int'(iorq_n), 1);
        chk("rst_wr_n", int'(wr_n), 1);
        chk("rst_rd_n", int'(rd_n), 1);
        chk("rst_cd_oe", int'(cd_oe), 0);
        chk("rst_ready", int'(req_ready), 0);
        reset     = 1'b0;
        req_valid = 1'b0;
        wait_n    = 1'b1;
        return;
      end
      strobe = (k >= 8) && (k < t3l);
      chk("A", int'(A), int'(addr));
      chk("iorq_n", int'(iorq_n), int'(!strobe));
      chk("rd_n", int'(rd_n), int'(!(strobe && !wr)));
      chk("wr_n", int'(wr_n), int'(!(strobe && wr)));
      chk("cd_oe", int'(cd_oe), int'(wr && k >= 4 && k < endo));
      if (wr && k >= 4 && k < endo) chk("cd_out", int'(cd_out), int'(wdata));
      chk("req_ready", int'(req_ready), int'(k == endo));
      if (k == endo) chk("rdata_hold", int'(rsp_rdata), int'(model_rdata));
      wait_n = ~((k >= 16) && (k <= 15 + 8 * n) && (k < endo));
      cd_in  = (k == t3l - 1) ? cap : (cap ^ 8'($urandom_range(1, 255)));
      if (k < endo) begin
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      if (k == rst_at) reset = 1'b1;
    end
  endtask

  logic       d_wr  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] d_addr[7] = '{8'h98, 8'h99, 8'h12, 8'h34, 8'h40, 8'h41, 8'h42};
  logic [7:0] d_wd  [7] = '{8'h5A, 8'h00, 8'h00, 8'h77, 8'h11, 8'h22, 8'h33};
  logic [7:0] d_cap [7] = '{8'h00, 8'hC3, 8'h6E, 8'h00, 8'h00, 8'h9B, 8'h00};
  int         d_n   [7] = '{0, 0, 1, 5, 0, 0, 0};
  logic       d_b2b [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [7:0] cap;
    int         n;
    logic       b2b;

    reset     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h55;
    req_wdata = 8'hAA;
    wait_n    = 1'b1;
    cd_in     = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_ready", int'(req_ready), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_rdata", int'(rsp_rdata), 0);
    chk("reset_rsp_timeout", int'(rsp_timeout), 0);
    chk("reset_A", int'(A), 0);
    chk("reset_iorq_n", int'(iorq_n), 1);
    chk("reset_rd_n", int'(rd_n), 1);
    chk("reset_wr_n", int'(wr_n), 1);
    chk("reset_cd_out", int'(cd_out), 0);
    chk("reset_cd_oe", int'(cd_oe), 0);
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(req_ready), 1);
    chk("A_after_reset", int'(A), 0);

    for (int i = 0; i < NTX; i++) begin
      if (i < 7) begin
        wr   = d_wr[i];
        addr = d_addr[i];
        wd   = d_wd[i];
        cap  = d_cap[i];
        n    = d_n[i];
        b2b  = d_b2b[i];
      end else begin
        wr   = 1'($urandom);
        addr = 8'($urandom);
        wd   = 8'($urandom);
        cap  = 8'($urandom);
        n    = $urandom_range(0, 4);
        b2b  = 1'($urandom);
      end
      if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_txn(wr, addr, wd, n, cap, -1);
    end

    // Reset in the middle of a write, then a normal read.
    repeat (2) @(negedge clk);
    run_txn(1'b1, 8'hB0, 8'hE1, 0, 8'h00, 12);
    model_rdata = 8'h00;
    @(negedge clk);
    chk("ready_after_midrst", int'(req_ready), 1);
    run_txn(1'b0, 8'hB1, 8'h00, 1, 8'h3C, -1);

    // Reset and a request in the same clock: the request is dropped.
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'hA5;
    @(negedge clk);
    chk("rstwin_ready", int'(req_ready), 0);
    chk("rstwin_A", int'(A), 0);
    chk("rstwin_iorq_n", int'(iorq_n), 1);
    reset       = 1'b0;
    req_valid   = 1'b0;
    model_rdata = 8'h00;
    @(negedge clk);
    chk("rstwin_ready_back", int'(req_ready), 1);
    repeat (10) begin
      @(negedge clk);
      chk("idle_iorq_n", int'(iorq_n), 1);
      chk("idle_A", int'(A), 0);
    end
    chk("rdata_after_rst", int'(rsp_rdata), int'(model_rdata));
    chk("queue_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
